// File: rtl/multiplexor_display7seg.sv
// Time-multiplexed N-digit 7-segment driver: per-frame input snapshot, hex decode,
// leading-zero suppression, per-digit enable/blink/decimal point and an anti-ghost blank interval.
module multiplexor_display7seg #(
    parameter int N_DIG          = 4,
    parameter int DIV            = 50000,
    parameter int BLANK          = 16,
    parameter int BLINK_FRAMES   = 64,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [4*N_DIG-1:0] valor,
    input  logic [N_DIG-1:0]   dp,
    input  logic [N_DIG-1:0]   habilita,
    input  logic [N_DIG-1:0]   parpadeo,
    input  logic               sup_ceros,
    output logic [N_DIG-1:0]   an,
    output logic [6:0]         seg,
    output logic               dp_o,
    output logic               fin_barrido
);

    localparam int PRE_W = $clog2(DIV);
    localparam int IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(DIV - 1);
    localparam logic [PRE_W-1:0] PRE_BLANK = PRE_W'(BLANK);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIG - 1);
    localparam logic [FRM_W-1:0] FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);

    localparam logic [6:0]       SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic             DP_OFF  = SEG_ACTIVE_LOW;
    localparam logic [N_DIG-1:0] AN_OFF  = AN_ACTIVE_LOW ? {N_DIG{1'b1}} : {N_DIG{1'b0}};

    // Active-high hex decode, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] decode_hex(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b0111111;
            4'h1:    s = 7'b0000110;
            4'h2:    s = 7'b1011011;
            4'h3:    s = 7'b1001111;
            4'h4:    s = 7'b1100110;
            4'h5:    s = 7'b1101101;
            4'h6:    s = 7'b1111101;
            4'h7:    s = 7'b0000111;
            4'h8:    s = 7'b1111111;
            4'h9:    s = 7'b1100111;
            4'hA:    s = 7'b1110111;
            4'hB:    s = 7'b1111100;
            4'hC:    s = 7'b0111001;
            4'hD:    s = 7'b1011110;
            4'hE:    s = 7'b1111001;
            4'hF:    s = 7'b1110001;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [FRM_W-1:0]   frm_q, frm_d;
    logic               phase_q, phase_d;
    logic [4*N_DIG-1:0] snap_valor_q, snap_valor_d;
    logic [N_DIG-1:0]   snap_dp_q, snap_dp_d;
    logic [N_DIG-1:0]   snap_hab_q, snap_hab_d;
    logic [N_DIG-1:0]   snap_parp_q, snap_parp_d;
    logic               snap_sup_q, snap_sup_d;
    logic [N_DIG-1:0]   an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    logic               dp_q, dp_d;
    logic               fin_q, fin_d;

    logic               pre_wrap_s, frame_end_s, frame_start_s, lit_s;
    logic [N_DIG-1:0]   lead_s, blank_s, an_act_s;
    logic               zeros_above_s;
    logic [3:0]         cur_nib_s;
    logic               cur_blank_s, cur_dp_s;

    // Scan counters, blink phase and frame-start snapshot.
    always_comb begin
        pre_wrap_s    = (pre_q == PRE_LAST);
        frame_end_s   = pre_wrap_s && (idx_q == IDX_LAST);
        frame_start_s = (pre_q == '0) && (idx_q == '0);
        pre_d         = pre_wrap_s ? '0 : pre_q + PRE_W'(1);
        idx_d         = idx_q;
        frm_d         = frm_q;
        phase_d       = phase_q;
        if (pre_wrap_s) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end else begin
            idx_d = idx_q;
        end
        if (frame_end_s) begin
            if (frm_q == FRM_LAST) begin
                frm_d   = '0;
                phase_d = ~phase_q;
            end else begin
                frm_d   = frm_q + FRM_W'(1);
            end
        end else begin
            frm_d = frm_q;
        end
        if (frame_start_s) begin
            snap_valor_d = valor;
            snap_dp_d    = dp;
            snap_hab_d   = habilita;
            snap_parp_d  = parpadeo;
            snap_sup_d   = sup_ceros;
        end else begin
            snap_valor_d = snap_valor_q;
            snap_dp_d    = snap_dp_q;
            snap_hab_d   = snap_hab_q;
            snap_parp_d  = snap_parp_q;
            snap_sup_d   = snap_sup_q;
        end
    end

    // Per-digit blanking, current-digit selection and pin-level output values.
    always_comb begin
        lead_s        = '0;
        blank_s       = '0;
        an_act_s      = '0;
        zeros_above_s = 1'b1;
        cur_nib_s     = 4'h0;
        cur_blank_s   = 1'b1;
        cur_dp_s      = 1'b0;
        // Leading means this nibble and every higher one are zero; digit 0 is never leading.
        for (int k = N_DIG - 1; k >= 0; k--) begin
            zeros_above_s = zeros_above_s && (snap_valor_q[4*k +: 4] == 4'h0);
            lead_s[k]     = zeros_above_s && (k != 0);
        end
        for (int k = 0; k < N_DIG; k++) begin
            blank_s[k] = !snap_hab_q[k] || (snap_sup_q && lead_s[k]) ||
                         (snap_parp_q[k] && phase_q);
            if (idx_q == IDX_W'(k)) begin
                cur_nib_s   = snap_valor_q[4*k +: 4];
                cur_blank_s = blank_s[k];
                cur_dp_s    = snap_dp_q[k];
                an_act_s[k] = 1'b1;
            end else begin
                an_act_s[k] = 1'b0;
            end
        end
        lit_s = (pre_q >= PRE_BLANK);
        if (lit_s) begin
            an_d  = AN_ACTIVE_LOW ? ~an_act_s : an_act_s;
            seg_d = cur_blank_s ? SEG_OFF : (SEG_ACTIVE_LOW ? ~decode_hex(cur_nib_s) : decode_hex(cur_nib_s));
            dp_d  = (!cur_blank_s && cur_dp_s) ? ~DP_OFF : DP_OFF;
        end else begin
            an_d  = AN_OFF;
            seg_d = SEG_OFF;
            dp_d  = DP_OFF;
        end
        fin_d = frame_end_s;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q        <= '0;
            idx_q        <= '0;
            frm_q        <= '0;
            phase_q      <= 1'b0;
            snap_valor_q <= '0;
            snap_dp_q    <= '0;
            snap_hab_q   <= '0;
            snap_parp_q  <= '0;
            snap_sup_q   <= 1'b0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_OFF;
            dp_q         <= DP_OFF;
            fin_q        <= 1'b0;
        end else begin
            pre_q        <= pre_d;
            idx_q        <= idx_d;
            frm_q        <= frm_d;
            phase_q      <= phase_d;
            snap_valor_q <= snap_valor_d;
            snap_dp_q    <= snap_dp_d;
            snap_hab_q   <= snap_hab_d;
            snap_parp_q  <= snap_parp_d;
            snap_sup_q   <= snap_sup_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            fin_q        <= fin_d;
        end
    end

    assign an          = an_q;
    assign seg         = seg_q;
    assign dp_o        = dp_q;
    assign fin_barrido = fin_q;

endmodule

// File: tb/tb_multiplexor_display7seg.sv
// Directed table-driven bench: two instances (active-high and active-low pins) share stimulus,
// every cycle of each frame is compared against hand-computed digit patterns.
module tb_multiplexor_display7seg;

    typedef struct {
        logic [15:0] valor;
        logic [3:0]  dp;
        logic [3:0]  hab;
        logic [3:0]  parp;
        logic        sup;
        logic [27:0] segs;   // {d3,d2,d1,d0} active-high, already blanked for enable/suppression
        logic [3:0]  dps;    // expected decimal point per digit
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] valor = 16'h0;
    logic [3:0]  dp = 4'h0, habilita = 4'h0, parpadeo = 4'h0;
    logic        sup_ceros = 1'b0;
    logic [3:0]  an_h, an_l;
    logic [6:0]  seg_h, seg_l;
    logic        dp_h, dp_l, fin_h, fin_l;

    int errors = 0;
    int checks = 0;
    int frame_no = 0;

    always #5 clk = ~clk;

    multiplexor_display7seg #(.N_DIG(4), .DIV(8), .BLANK(2), .BLINK_FRAMES(2),
        .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)) dut_h (
        .clk(clk), .rst_n(rst_n), .valor(valor), .dp(dp), .habilita(habilita),
        .parpadeo(parpadeo), .sup_ceros(sup_ceros), .an(an_h), .seg(seg_h),
        .dp_o(dp_h), .fin_barrido(fin_h));

    multiplexor_display7seg #(.N_DIG(4), .DIV(8), .BLANK(2), .BLINK_FRAMES(2),
        .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut_l (
        .clk(clk), .rst_n(rst_n), .valor(valor), .dp(dp), .habilita(habilita),
        .parpadeo(parpadeo), .sup_ceros(sup_ceros), .an(an_l), .seg(seg_l),
        .dp_o(dp_l), .fin_barrido(fin_l));

    task automatic check(input string name, input logic [25:0] act, input logic [25:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [25:0] outs();
        return {an_h, seg_h, dp_h, fin_h, an_l, seg_l, dp_l, fin_l};
    endfunction

    localparam logic [25:0] IDLE = {4'h0, 7'h00, 1'b0, 1'b0, 4'hF, 7'h7F, 1'b1, 1'b0};

    // One full frame starting at the next posedge; optional mid-frame input change or reset.
    task automatic run_frame(input vec_t v, input int chg_at, input logic [15:0] chg_val,
                             input int rst_at);
        int slot, p;
        logic phase, bb, edp, efin;
        logic [3:0] ean;
        logic [6:0] eseg;
        valor = v.valor; dp = v.dp; habilita = v.hab; parpadeo = v.parp; sup_ceros = v.sup;
        for (int c = 0; c < 32; c++) begin
            @(posedge clk);
            @(negedge clk);
            slot  = c / 8;
            p     = c % 8;
            phase = ((frame_no / 2) % 2) == 1;
            ean = 4'h0; eseg = 7'h00; edp = 1'b0;
            if (p >= 2) begin
                ean  = 4'b0001 << slot;
                bb   = v.parp[slot] && phase;
                eseg = bb ? 7'h00 : v.segs[7*slot +: 7];
                edp  = !bb && v.dps[slot];
            end
            efin = (c == 31);
            check($sformatf("frame%0d cyc%0d", frame_no, c), outs(),
                  {ean, eseg, edp, efin, ~ean, ~eseg, ~edp, efin});
            if (c == chg_at) valor = chg_val;
            if (c == rst_at) begin
                rst_n = 1'b0;
                #1;
                check("async reset", outs(), IDLE);
                @(negedge clk);
                @(negedge clk);
                check("reset held", outs(), IDLE);
                rst_n = 1'b1;
                frame_no = 0;
                return;
            end
        end
        frame_no++;
    endtask

    vec_t vecs[7];
    vec_t v1111, vabcd, vblink;

    initial begin
        vecs[0] = '{16'h1234, 4'h0, 4'hF, 4'h0, 1'b0, {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'h0};
        vecs[1] = '{16'h0070, 4'h0, 4'hF, 4'h0, 1'b1, {7'h00, 7'h00, 7'h07, 7'h3F}, 4'h0};
        vecs[2] = '{16'h0000, 4'h0, 4'hF, 4'h0, 1'b1, {7'h00, 7'h00, 7'h00, 7'h3F}, 4'h0};
        vecs[3] = '{16'h0000, 4'h0, 4'hF, 4'h0, 1'b0, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'h0};
        vecs[4] = '{16'h89EF, 4'h4, 4'hF, 4'h0, 1'b0, {7'h7F, 7'h67, 7'h79, 7'h71}, 4'h4};
        vecs[5] = '{16'h0560, 4'hF, 4'hA, 4'h0, 1'b1, {7'h00, 7'h00, 7'h7D, 7'h00}, 4'h2};
        vecs[6] = '{16'h0300, 4'h0, 4'hB, 4'h0, 1'b1, {7'h00, 7'h00, 7'h3F, 7'h3F}, 4'h0};
        v1111   = '{16'h1111, 4'h0, 4'hF, 4'h0, 1'b0, {7'h06, 7'h06, 7'h06, 7'h06}, 4'h0};
        vabcd   = '{16'hABCD, 4'h0, 4'hF, 4'h0, 1'b0, {7'h77, 7'h7C, 7'h39, 7'h5E}, 4'h0};
        vblink  = '{16'h1234, 4'h0, 4'hF, 4'h1, 1'b0, {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'h0};

        #2 rst_n = 1'b0;
        #1 check("power-on reset", outs(), IDLE);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_frame(vecs[i], -1, 16'h0, -1);
        run_frame(v1111, 13, 16'hABCD, -1);
        run_frame(vabcd, -1, 16'h0, -1);
        for (int i = 0; i < 4; i++) run_frame(vblink, -1, 16'h0, -1);
        run_frame(vecs[0], -1, 16'h0, 20);
        run_frame(vecs[3], -1, 16'h0, -1);
        run_frame(vblink, -1, 16'h0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multiplexor_display7seg.md
# multiplexor_display7seg

Time-multiplexed driver for an N-digit common-anode/cathode 7-segment display bank. It is the parametrised successor of the single-digit combinational decoder. It snapshots packed per-digit nibbles once per scan frame and decodes full hex (0–F). It adds leading-zero suppression, per-digit enable/blink and decimal points, plus an anti-ghosting blank interval. It sits between the datapath (counters, BCD converters) and the board pins.

## Interface
- `N_DIG`, 4: number of digits, 1..8
- `DIV`, 50000: clock cycles per digit slot, ≥2
- `BLANK`, 16: cycles at slot start with all anodes off; 1 ≤ BLANK < DIV
- `BLINK_FRAMES`, 64: frames per blink half-period, ≥1
- `SEG_ACTIVE_LOW`, 1: invert `seg` and `dp_o` at the pins
- `AN_ACTIVE_LOW`, 1: invert `an` at the pins
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous, active-low reset
- `valor`  in  4*N_DIG  packed nibbles; digit k = `valor[4k+3:4k]`, digit 0 rightmost
- `dp`  in  N_DIG  decimal point per digit
- `habilita`  in  N_DIG  digit enable; 0 = always blank
- `parpadeo`  in  N_DIG  digit blinks when 1
- `sup_ceros`  in  1  leading-zero suppression enable
- `an`  out  N_DIG  anode selects, one-hot or all-off
- `seg`  out  7  segments, `seg[6:0]` = {g,f,e,d,c,b,a}
- `dp_o`  out  1  decimal point segment
- `fin_barrido`  out  1  one-cycle pulse at end of each frame

## Operation
- Prescaler `pre` counts 0..DIV-1 and wraps. On wrap, digit index `idx` advances 0→1→…→N_DIG-1→0. One frame is N_DIG*DIV cycles.
- Snapshot: on every edge where `pre==0 && idx==0` (frame start), `valor`, `dp`, `habilita`, `parpadeo` and `sup_ceros` are registered. Only the snapshot drives the display, so there is no tearing within a frame.
- Active-high decode, constants {g..a}:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1100111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001
- Leading-zero suppression, applied only when the snapshot `sup_ceros` is 1: digit k is "leading" when nibbles k..N_DIG-1 are all 0. Digit 0 is never suppressed. Disabled digits still count by their nibble value.
- Digit k is blank when any of the following holds: `habilita[k]`=0; k is leading and suppressed; `parpadeo[k]`=1 and blink phase=1.
  - A blank digit drives segments all off and `dp_o` off.
  - Its anode is still driven during the active part of its slot.
- Blink: a frame counter runs 0..BLINK_FRAMES-1, and phase toggles when it wraps at a frame end. Phase resets to 0.
- Anti-ghost: while `pre < BLANK`, `an` is all inactive. Otherwise `an[idx]` alone is active.
- Polarity parameters are applied at the output registers only. All internal logic is active-high.

## Timing
- `an`, `seg`, `dp_o` and `fin_barrido` are registered. Their value after edge E is computed from `pre`/`idx`/snapshot as they stood before E.
- Latency:
  - A snapshot loaded at edge E first appears on `an[0]`/`seg` after edge E+BLANK.
  - Each digit is lit for DIV-BLANK cycles per slot.
- `fin_barrido` is high for the cycle following the edge where `pre==DIV-1 && idx==N_DIG-1`.
- Reset (async assert, any time including mid-frame) sets all of the following immediately:
  - `pre`=0, `idx`=0, frame counter=0, blink phase=0, snapshot=0
  - `an` all inactive, `seg` all off, `dp_o` off, `fin_barrido`=0 (inactive levels per polarity parameters)
- After release, the first edge is a frame start and takes a snapshot.
- Input changes between frame starts have no visible effect until the next frame start.
- Changes at the exact frame-start edge are captured.

## Test plan
- N_DIG=4, DIV=8, BLANK=2, active-high pins; `valor`=0x1234, all `habilita`=1 → per slot, `an`=0000 for 2 cycles then `an[k]` for 6 cycles; `seg` shows 4,3,2,1 as 1100110,1001111,1011011,0000110 for digits 0..3; `fin_barrido` pulses every 32 cycles.
- `valor`=0x0070, `sup_ceros`=1 → digits 3 and 2 blank, digit 1 shows 0000111, digit 0 shows 0111111. `valor`=0x0000 → only digit 0 shows 0111111.
- Change `valor` from 0x1111 to 0xABCD mid-frame → the current frame shows only 1s; the next frame shows d,C,b,A.
- BLINK_FRAMES=2, `parpadeo`=0001 → digit 0 is lit for frames 0–1, blank for frames 2–3, and so on; other digits are unaffected.
- SEG_ACTIVE_LOW=AN_ACTIVE_LOW=1, `dp`=0100 → the lit anode is 0 while others are 1; `dp_o`=0 only during digit 2's active window.
- Assert `rst_n`=0 mid-slot 2 → outputs go inactive without waiting for a clock edge; after release, scanning restarts at digit 0 with a fresh snapshot.
